// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and writeback select for the RV32I core.
// Optional retired-instruction counter on `instret`, enabled by defining WB_INSTRET_EN.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_regwrite,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wbsel,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic [XLEN-1:0]  in_pc,
  output logic             wreg,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wrdata,
  output logic             retire_valid,
  output logic [XLEN-1:0]  retire_pc,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;

  logic [7:0]      lane [4];
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;
  logic            load_bad;
  logic [XLEN-1:0] result_c;
  logic            err_c;
  logic            live;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = in_load_data[8*gi +: 8];
  end

  // Load alignment and extension; error flags misaligned halves/words and unknown funct3.
  always_comb begin
    off      = in_alu_result[1:0];
    byte_sel = lane[off];
    half_sel = off[1] ? in_load_data[31:16] : in_load_data[15:0];
    load_val = in_load_data;
    load_bad = 1'b0;
    case (in_funct3)
      3'b000: load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_val = {24'b0, byte_sel};
      3'b001: begin
        load_val = {{16{half_sel[15]}}, half_sel};
        load_bad = off[0];
      end
      3'b101: begin
        load_val = {16'b0, half_sel};
        load_bad = off[0];
      end
      3'b010: begin
        load_val = in_load_data;
        load_bad = (off != 2'b00);
      end
      default: load_bad = 1'b1;
    endcase
  end

  always_comb begin
    result_c = in_alu_result;
    err_c    = 1'b0;
    case (in_wbsel)
      2'd1: begin
        result_c = load_val;
        err_c    = load_bad;
      end
      2'd2:    result_c = in_pc + XLEN'(4);
      default: result_c = in_alu_result;
    endcase
  end

  // Flush beats stall; on flush the fields are left as they were since valid_q masks them.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    result_d   = result_q;
    pc_d       = pc_q;
    err_d      = err_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d    = in_valid;
      regwrite_d = in_regwrite;
      rd_d       = in_rd;
      result_d   = result_c;
      pc_d       = in_pc;
      err_d      = err_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      pc_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
    end
  end

  assign in_ready     = !stall;
  assign live         = valid_q & !stall;
  assign wreg         = live & regwrite_q & (rd_q != 5'd0) & !err_q;
  assign waddr        = valid_q ? rd_q : 5'd0;
  assign wrdata       = valid_q ? result_q : '0;
  assign retire_valid = live & !err_q;
  assign retire_pc    = pc_q;
  assign load_err     = live & err_q;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (retire_valid) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed plan cases then randomized traffic against a behavioural model.
module tb_wb_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, stall, flush, in_regwrite;
  logic [4:0]       in_rd;
  logic [1:0]       in_wbsel;
  logic [2:0]       in_funct3;
  logic [31:0]      in_alu_result, in_load_data, in_pc;
  logic             in_ready, wreg, retire_valid, load_err;
  logic [4:0]       waddr;
  logic [31:0]      wrdata, retire_pc;
  logic [CNT_W-1:0] instret;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_wbsel(in_wbsel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_load_data(in_load_data), .in_pc(in_pc), .wreg(wreg), .waddr(waddr),
    .wrdata(wrdata), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .load_err(load_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wrdata;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  bit   pending = 1'b0;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference: pick the addressed byte/half by shifting the word, extend arithmetically.
  function automatic void ref_model(input logic [1:0] wbsel, input logic [2:0] f3,
                                    input logic [31:0] alu, input logic [31:0] ld,
                                    input logic [31:0] pc, output logic [31:0] res,
                                    output logic err);
    int unsigned off;
    logic [31:0] b, h;
    off = alu % 4;
    b   = (ld >> (8 * off)) & 32'h0000_00FF;
    h   = (ld >> (16 * (off / 2))) & 32'h0000_FFFF;
    res = alu;
    err = 1'b0;
    if (wbsel == 2'd2) begin
      res = pc + 32'd4;
    end else if (wbsel == 2'd1) begin
      case (f3)
        3'd0: res = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
        3'd4: res = b;
        3'd1: begin res = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h; err = (off % 2) != 0; end
        3'd5: begin res = h; err = (off % 2) != 0; end
        3'd2: begin res = ld; err = off != 0; end
        default: err = 1'b1;
      endcase
    end
  endfunction

  task automatic cycle(input int rs, input int v, input int st, input int fl, input int rw,
                       input int rd, input int ws, input int f3, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc);
    logic [31:0] res;
    logic        err;
    exp_t        e;
    rst_n = rs[0]; in_valid = v[0]; stall = st[0]; flush = fl[0];
    in_regwrite = rw[0]; in_rd = 5'(rd); in_wbsel = 2'(ws); in_funct3 = 3'(f3);
    in_alu_result = alu; in_load_data = ld; in_pc = pc;
    @(posedge clk);
    #1;
    if (pending && st == 0) pending = 1'b0;
    if (rs == 0 || fl != 0) begin
      if (pending) begin
        void'(sb.pop_back());
        pending = 1'b0;
      end
    end else if (st == 0 && v != 0) begin
      ref_model(2'(ws), 3'(f3), alu, ld, pc, res, err);
      e.wreg   = (rw != 0) && (rd % 32 != 0) && !err;
      e.waddr  = 5'(rd);
      e.wrdata = res;
      e.err    = err;
      e.pc     = pc;
      sb.push_back(e);
      pending = 1'b1;
    end
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: every cycle either the oldest pending entry is visible or nothing is.
  initial begin
    bit          prev_rst = 1'b0;
    logic [63:0] exp_cnt = 64'd0;
    bit          exp_ret;
    exp_t        e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ret = 1'b0;
      chk("in_ready", 64'(in_ready), 64'(!stall));
      if (!prev_rst) begin
        chk("rst_wreg", 64'(wreg), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wrdata", 64'(wrdata), 64'd0);
        chk("rst_retire", 64'(retire_valid), 64'd0);
        chk("rst_retire_pc", 64'(retire_pc), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
      end else if (stall || sb.size() == 0) begin
        chk("quiet_wreg", 64'(wreg), 64'd0);
        chk("quiet_retire", 64'(retire_valid), 64'd0);
        chk("quiet_load_err", 64'(load_err), 64'd0);
        if (sb.size() == 0) begin
          chk("empty_waddr", 64'(waddr), 64'd0);
          chk("empty_wrdata", 64'(wrdata), 64'd0);
        end
      end else begin
        e = sb.pop_front();
        exp_ret = !e.err;
        $display("txn t=%0t waddr=%0d wrdata=%h wreg=%0b retire=%0b load_err=%0b pc=%h",
                 $time, waddr, wrdata, wreg, retire_valid, load_err, retire_pc);
        chk("wreg", 64'(wreg), 64'(e.wreg));
        chk("waddr", 64'(waddr), 64'(e.waddr));
        chk("retire_valid", 64'(retire_valid), 64'(!e.err));
        chk("load_err", 64'(load_err), 64'(e.err));
        chk("retire_pc", 64'(retire_pc), 64'(e.pc));
        if (!e.err) chk("wrdata", 64'(wrdata), 64'(e.wrdata));
      end
`ifdef WB_INSTRET_EN
      chk("instret", 64'(instret), exp_cnt);
`else
      chk("instret_tied", 64'(instret), 64'd0);
`endif
      if (exp_ret) exp_cnt = exp_cnt + 64'd1;
      if (!rst_n) exp_cnt = 64'd0;
      prev_rst = rst_n;
    end
  end

  initial begin
    int rs, v, st, fl, rw, rd, ws, f3;
    logic [31:0] alu, ld, pc;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cycle(0, 1, 0, 0, 1, 3, 0, 0, 32'h1234, 32'h0, 32'h0);
    idle();
    // ALU write, then two idle cycles confirm a single pulse
    cycle(1, 1, 0, 0, 1, 5, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0000_0100);
    idle();
    idle();
    // Loads on 0x8070F0A5
    cycle(1, 1, 0, 0, 1, 6, 1, 0, 32'h0000_1000, 32'h8070F0A5, 32'h0000_0200);
    cycle(1, 1, 0, 0, 1, 7, 1, 4, 32'h0000_1001, 32'h8070F0A5, 32'h0000_0204);
    cycle(1, 1, 0, 0, 1, 8, 1, 1, 32'h0000_1002, 32'h8070F0A5, 32'h0000_0208);
    cycle(1, 1, 0, 0, 1, 9, 1, 5, 32'h0000_1002, 32'h8070F0A5, 32'h0000_020C);
    cycle(1, 1, 0, 0, 1, 10, 1, 2, 32'h0000_1000, 32'h8070F0A5, 32'h0000_0210);
    cycle(1, 1, 0, 0, 1, 11, 1, 2, 32'h0000_1002, 32'h8070F0A5, 32'h0000_0214);
    // JAL link wrap
    cycle(1, 1, 0, 0, 1, 1, 2, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    idle();
    // Stall three cycles, then release
    cycle(1, 1, 0, 0, 1, 12, 0, 0, 32'h0000_00AA, 32'h0, 32'h0000_0300);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 1, 13, 0, 0, 32'h0000_00BB, 32'h0, 32'h0000_0304);
    idle();
    idle();
    // Flush with stall drops the held entry; flush with in_valid captures nothing
    cycle(1, 1, 0, 0, 1, 14, 0, 0, 32'h0000_00CC, 32'h0, 32'h0000_0400);
    cycle(1, 0, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    idle();
    cycle(1, 1, 0, 1, 1, 15, 0, 0, 32'h0000_00DD, 32'h0, 32'h0000_0404);
    idle();
    // rd0 retires without writing; then reset while an entry is held
    cycle(1, 1, 0, 0, 1, 0, 0, 0, 32'h0000_00EE, 32'h0, 32'h0000_0500);
    idle();
    cycle(1, 1, 0, 0, 1, 16, 0, 0, 32'h0000_00FF, 32'h0, 32'h0000_0504);
    cycle(0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    idle();
    idle();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 99) != 0) ? 1 : 0;
      st  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      fl  = ($urandom_range(0, 11) == 0) ? 1 : 0;
      v   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rw  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rd  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      ws  = int'($urandom_range(0, 3));
      f3  = int'($urandom_range(0, 7));
      alu = $urandom;
      ld  = $urandom;
      pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(rs, v, st, fl, rw, rd, ws, f3, alu, ld, pc);
    end
    idle();
    idle();
    idle();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
